// File: rtl/joy_shift_reader_pkg.sv
// Shared types and constants for the controller shift-chain reader.
package joy_shift_reader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT_LO,
    SHIFT_HI,
    LATCH
  } state_t;

  localparam int unsigned MAX_PLAYERS = 4;
  localparam int unsigned MAX_BITS    = 16;

  // Total number of bits clocked out of the chain in one frame.
  function automatic int unsigned frame_width(input int unsigned players,
                                              input int unsigned bits);
    return players * bits;
  endfunction

endpackage

// File: rtl/joy_tick_gen.sv
// Free-running divider: one-clk tick every CLK_DIV clk cycles.
module joy_tick_gen #(
  parameter int unsigned CLK_DIV = 24
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Divider counter, wraps after CLK_DIV cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/joy_shift_reader.sv
// Scans a chain of parallel-load shift registers (joystick controllers),
// filters frames for stability and publishes active-high button state.
module joy_shift_reader
  import joy_shift_reader_pkg::*;
#(
  parameter int unsigned PLAYERS = 2,
  parameter int unsigned BITS    = 12,
  parameter int unsigned CLK_DIV = 24,
  parameter int unsigned GAP     = 16,
  parameter int unsigned FILTER  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    ser_data,
  output logic                    ser_clk,
  output logic                    ser_load,
  output logic [PLAYERS*BITS-1:0] joystick,
  output logic                    valid,
  output logic                    frame_err
);

  localparam int unsigned FRAME_W = frame_width(PLAYERS, BITS);
  localparam int unsigned IDX_W   = $clog2(FRAME_W);
  localparam int unsigned GAP_W   = $clog2(GAP + 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(FRAME_W - 1);
  localparam logic [GAP_W-1:0] GAP_END    = GAP_W'(GAP);
  localparam logic [2:0]       MATCH_GOAL = 3'(FILTER - 1);

  state_t             state, next_state;
  logic               tick;
  logic [1:0]         sync_ff;
  logic               din;
  logic [IDX_W-1:0]   bit_idx;
  logic [GAP_W-1:0]   gap_cnt;
  logic [FRAME_W-1:0] frame_buf;
  logic [FRAME_W-1:0] raw_frame;
  logic [2:0]         match_cnt;
  logic [2:0]         match_inc;
  logic               take_bit;

  joy_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Two-flop synchroniser for the asynchronous chain data (idles released).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_ff <= 2'b11;
    else       sync_ff <= {sync_ff[0], ser_data};
  end

  assign din       = sync_ff[1];
  assign match_inc = (match_cnt == 3'd7) ? 3'd7 : match_cnt + 3'd1;
  assign take_bit  = (state == LOAD || state == SHIFT_HI) && (next_state == SHIFT_LO);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and chain control lines.
  always_comb begin
    next_state = state;
    ser_clk    = 1'b1;
    ser_load   = 1'b1;
    case (state)
      IDLE: begin
        if (tick && gap_cnt == GAP_END && enable) next_state = LOAD;
      end
      LOAD: begin
        ser_load = 1'b0;
        if (tick) next_state = enable ? SHIFT_LO : IDLE;
      end
      SHIFT_LO: begin
        ser_clk = 1'b0;
        if (tick) next_state = enable ? SHIFT_HI : IDLE;
      end
      SHIFT_HI: begin
        if (tick) begin
          if (!enable)                next_state = IDLE;
          else if (bit_idx == LAST_IDX) next_state = LATCH;
          else                        next_state = SHIFT_LO;
        end
      end
      LATCH:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Gap/bit counters, frame capture, stability filter and publishing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_cnt   <= GAP_W'(1);
      bit_idx   <= '0;
      frame_buf <= '0;
      raw_frame <= '0;
      match_cnt <= '0;
      joystick  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;

      // LATCH starts a tick slot that counts towards the gap, so the gap
      // counter starts one lower there than after reset or an abort.
      if (state == LATCH)
        gap_cnt <= '0;
      else if (state != IDLE && next_state == IDLE)
        gap_cnt <= GAP_W'(1);
      else if (state == IDLE && tick && gap_cnt != GAP_END)
        gap_cnt <= gap_cnt + 1'b1;

      if (state == LOAD)
        bit_idx <= '0;
      else if (state == SHIFT_HI && tick && enable)
        bit_idx <= bit_idx + 1'b1;

      // Bits arrive in index order, so shifting in from the top leaves the
      // first sample at bit 0 once the frame is complete.
      if (take_bit)
        frame_buf <= {~din, frame_buf[FRAME_W-1:1]};

      if (state == LATCH) begin
        if (FILTER == 1) begin
          raw_frame <= frame_buf;
          match_cnt <= '0;
          if (frame_buf != joystick) begin
            joystick <= frame_buf;
            valid    <= 1'b1;
          end
        end else if (frame_buf == raw_frame) begin
          match_cnt <= match_inc;
          if (match_inc >= MATCH_GOAL && frame_buf != joystick) begin
            joystick <= frame_buf;
            valid    <= 1'b1;
          end
        end else begin
          match_cnt <= '0;
          raw_frame <= frame_buf;
          frame_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_joy_shift_reader.sv
// Directed bench for joy_shift_reader with behavioural controller chains.
module tb_joy_shift_reader;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic        ser_data, ser_clk, ser_load, valid, frame_err;
  logic [23:0] joystick;

  logic        rst2, en2;
  logic        ser_data2, ser_clk2, ser_load2, valid2, frame_err2;
  logic [63:0] joystick2;

  logic [23:0] pat1 = '1;
  logic [23:0] sr1  = '1;
  logic [63:0] pat2 = '1;
  logic [63:0] sr2  = '1;

  int checks = 0;
  int errors = 0;
  int n_valid = 0, n_err = 0, n_valid2 = 0, n_err2 = 0, n_both = 0;

  always #5 clk = ~clk;

  joy_shift_reader dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .ser_data  (ser_data),
    .ser_clk   (ser_clk),
    .ser_load  (ser_load),
    .joystick  (joystick),
    .valid     (valid),
    .frame_err (frame_err)
  );

  joy_shift_reader #(.PLAYERS(4), .BITS(16), .FILTER(1)) dut_wide (
    .clk       (clk),
    .reset     (rst2),
    .enable    (en2),
    .ser_data  (ser_data2),
    .ser_clk   (ser_clk2),
    .ser_load  (ser_load2),
    .joystick  (joystick2),
    .valid     (valid2),
    .frame_err (frame_err2)
  );

  // Chain models: parallel load while ser_load low, shift on ser_clk rise.
  always @(posedge ser_clk or negedge ser_load)
    if (!ser_load) sr1 <= pat1;
    else           sr1 <= {1'b1, sr1[23:1]};
  assign ser_data = sr1[0];

  always @(posedge ser_clk2 or negedge ser_load2)
    if (!ser_load2) sr2 <= pat2;
    else            sr2 <= {1'b1, sr2[63:1]};
  assign ser_data2 = sr2[0];

  // Pulse counters sampled on the inactive edge.
  always @(negedge clk) begin
    if (valid)      n_valid  <= n_valid + 1;
    if (frame_err)  n_err    <= n_err + 1;
    if (valid2)     n_valid2 <= n_valid2 + 1;
    if (frame_err2) n_err2   <= n_err2 + 1;
    if ((valid && frame_err) || (valid2 && frame_err2)) n_both <= n_both + 1;
  end

  // Waits for the next ser_load fall; reports clks waited and ser_clk falls.
  task automatic wait_load_fall(output int unsigned clks, output int unsigned falls);
    logic pl, pc;
    bit   found;
    pl = ser_load; pc = ser_clk; clks = 0; falls = 0; found = 0;
    while (!found && clks < 4000) begin
      @(posedge clk); #1;
      clks++;
      if (pc && !ser_clk) falls++;
      if (pl && !ser_load) found = 1;
      pl = ser_load; pc = ser_clk;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL load_timeout: no ser_load fall within %0d clks", clks);
    end
  endtask

  task automatic test_reset();
    int unsigned c, f;
    int vb, eb;
    reset = 1'b1; enable = 1'b1; rst2 = 1'b1; en2 = 1'b1;
    pat1 = 24'hFFFFFF;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ser_clk !== 1'b1)   begin errors++; $display("FAIL rst_ser_clk: got %b want 1", ser_clk); end
    checks++; if (ser_load !== 1'b1)  begin errors++; $display("FAIL rst_ser_load: got %b want 1", ser_load); end
    checks++; if (joystick !== 24'h0) begin errors++; $display("FAIL rst_joystick: got %h want 000000", joystick); end
    checks++; if (valid !== 1'b0)     begin errors++; $display("FAIL rst_valid: got %b want 0", valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_frame_err: got %b want 0", frame_err); end
    checks++; if (joystick2 !== 64'h0) begin errors++; $display("FAIL rst_joystick2: got %h want 0", joystick2); end
    @(negedge clk) reset = 1'b0;
    wait_load_fall(c, f);
    checks++; if (c != 384) begin errors++; $display("FAIL first_load_delay: got %0d want 384", c); end
    vb = n_valid; eb = n_err;
    wait_load_fall(c, f);
    checks++; if (c != 1584) begin errors++; $display("FAIL frame_period: got %0d want 1584", c); end
    checks++; if (f != 24)   begin errors++; $display("FAIL sclk_pulses: got %0d want 24", f); end
    checks++; if (n_valid != vb || n_err != eb)
      begin errors++; $display("FAIL idle_frame_pulses: valid %0d err %0d want 0 0", n_valid - vb, n_err - eb); end
  endtask

  task automatic test_filter();
    int unsigned c, f;
    int vb, eb;
    pat1 = 24'hFFFFFE;
    vb = n_valid; eb = n_err;
    wait_load_fall(c, f);
    wait_load_fall(c, f);
    checks++; if (joystick !== 24'h0 || n_valid != vb || n_err != eb + 1)
      begin errors++; $display("FAIL filter_first: joy %h valid %0d err %0d want 000000 0 1", joystick, n_valid - vb, n_err - eb); end
    wait_load_fall(c, f);
    checks++; if (joystick !== 24'h000001) begin errors++; $display("FAIL filter_publish: got %h want 000001", joystick); end
    checks++; if (n_valid != vb + 1) begin errors++; $display("FAIL filter_valid: got %0d want 1", n_valid - vb); end
    wait_load_fall(c, f);
    wait_load_fall(c, f);
    checks++; if (n_valid != vb + 1 || n_err != eb + 1)
      begin errors++; $display("FAIL filter_steady: valid %0d err %0d want 1 1", n_valid - vb, n_err - eb); end
  endtask

  task automatic test_glitch();
    int unsigned c, f;
    int vb, eb;
    pat1 = 24'hFF7FFE;
    vb = n_valid; eb = n_err;
    wait_load_fall(c, f);
    pat1 = 24'hFFFFFE;
    wait_load_fall(c, f);
    checks++; if (n_err != eb + 1 || joystick !== 24'h000001)
      begin errors++; $display("FAIL glitch_frame: err %0d joy %h want 1 000001", n_err - eb, joystick); end
    wait_load_fall(c, f);
    wait_load_fall(c, f);
    checks++; if (n_err != eb + 2) begin errors++; $display("FAIL glitch_err_count: got %0d want 2", n_err - eb); end
    checks++; if (n_valid != vb || joystick !== 24'h000001)
      begin errors++; $display("FAIL glitch_hold: valid %0d joy %h want 0 000001", n_valid - vb, joystick); end
  endtask

  task automatic test_abort();
    int unsigned c, f, lo_cnt, guard, stray;
    int vb, eb;
    logic pc, pl;
    pat1 = 24'hFFFFFC;
    vb = n_valid; eb = n_err;
    wait_load_fall(c, f);
    lo_cnt = 0; guard = 0; pc = ser_clk;
    while (lo_cnt < 5 && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
      if (pc && !ser_clk) lo_cnt++;
      pc = ser_clk;
    end
    checks++; if (lo_cnt != 5) begin errors++; $display("FAIL abort_reach_lo5: got %0d want 5", lo_cnt); end
    enable = 1'b0;
    repeat (24) @(posedge clk);
    #1;
    checks++; if (ser_clk !== 1'b1 || ser_load !== 1'b1)
      begin errors++; $display("FAIL abort_lines: clk %b load %b want 1 1", ser_clk, ser_load); end
    stray = 0; pc = ser_clk; pl = ser_load;
    repeat (3000) begin
      @(posedge clk); #1;
      if ((pc && !ser_clk) || (pl && !ser_load)) stray++;
      pc = ser_clk; pl = ser_load;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL abort_quiet: got %0d edges want 0", stray); end
    checks++; if (n_valid != vb || n_err != eb || joystick !== 24'h000001)
      begin errors++; $display("FAIL abort_no_latch: valid %0d err %0d joy %h want 0 0 000001", n_valid - vb, n_err - eb, joystick); end
    enable = 1'b1;
    wait_load_fall(c, f);
    wait_load_fall(c, f);
    checks++; if (f != 24 || c != 1584)
      begin errors++; $display("FAIL reenable_frame: pulses %0d clks %0d want 24 1584", f, c); end
    checks++; if (n_err != eb + 1 || joystick !== 24'h000001)
      begin errors++; $display("FAIL reenable_first: err %0d joy %h want 1 000001", n_err - eb, joystick); end
    wait_load_fall(c, f);
    checks++; if (joystick !== 24'h000003 || n_valid != vb + 1)
      begin errors++; $display("FAIL reenable_publish: joy %h valid %0d want 000003 1", joystick, n_valid - vb); end
  endtask

  task automatic test_reset_mid();
    int unsigned c, f, guard;
    int vb, eb;
    logic pc;
    wait_load_fall(c, f);
    guard = 0; pc = ser_clk;
    while (!(!pc && ser_clk) && guard < 200) begin
      pc = ser_clk;
      @(posedge clk); #1;
      guard++;
    end
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checks++; if (joystick !== 24'h0 || ser_clk !== 1'b1 || ser_load !== 1'b1)
      begin errors++; $display("FAIL midreset_now: joy %h clk %b load %b want 000000 1 1", joystick, ser_clk, ser_load); end
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    vb = n_valid; eb = n_err;
    wait_load_fall(c, f);
    checks++; if (c != 384) begin errors++; $display("FAIL midreset_delay: got %0d want 384", c); end
    wait_load_fall(c, f);
    checks++; if (joystick !== 24'h0 || n_valid != vb || n_err != eb + 1)
      begin errors++; $display("FAIL midreset_first: joy %h valid %0d err %0d want 000000 0 1", joystick, n_valid - vb, n_err - eb); end
    wait_load_fall(c, f);
    checks++; if (joystick !== 24'h000003 || n_valid != vb + 1)
      begin errors++; $display("FAIL midreset_publish: joy %h valid %0d want 000003 1", joystick, n_valid - vb); end
  endtask

  task automatic test_wide();
    logic [63:0] exp_joy;
    int unsigned guard;
    exp_joy = 64'h0123_4567_89AB_CDEF;
    pat2 = ~exp_joy;
    @(negedge clk) rst2 = 1'b0;
    guard = 0;
    while (n_valid2 == 0 && guard < 6000) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++; if (joystick2 !== exp_joy)
      begin errors++; $display("FAIL wide_pattern: got %h want %h", joystick2, exp_joy); end
    repeat (4000) @(posedge clk);
    #1;
    checks++; if (n_valid2 != 1 || n_err2 != 0)
      begin errors++; $display("FAIL wide_pulses: valid %0d err %0d want 1 0", n_valid2, n_err2); end
  endtask

  initial begin
    test_reset();
    test_filter();
    test_glitch();
    test_abort();
    test_reset_mid();
    test_wide();
    checks++; if (n_both != 0) begin errors++; $display("FAIL valid_err_overlap: got %0d want 0", n_both); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/joy_shift_reader.md
JOY_SHIFT_READER -- requirements
Module: joy_shift_reader

Interface
REQ-001 Parameter PLAYERS, 2, number of controllers in the shift chain (1..4).
REQ-002 Parameter BITS, 12, bits clocked per controller (4..16).
REQ-003 Parameter CLK_DIV, 24, clk cycles per tick (>=2).
REQ-004 Parameter GAP, 16, idle ticks between frames (>=1).
REQ-005 Parameter FILTER, 2, consecutive identical frames required before publishing (1..7).
REQ-006 clk  in  1  system clock, 40-50 MHz; the only clock.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 enable  in  1  1 = scanning runs; 0 = scanning halts at the next tick.
REQ-009 ser_data  in  1  serial data from the chain, active-low per button, asynchronous to clk.
REQ-010 ser_clk  out  1  shift clock to the chain; idle high.
REQ-011 ser_load  out  1  parallel-load strobe to the chain, active-low; idle high.
REQ-012 joystick  out  PLAYERS*BITS  filtered buttons, active-high; player p occupies bits [p*BITS +: BITS].
REQ-013 valid  out  1  one-clk pulse when joystick is updated.
REQ-014 frame_err  out  1  one-clk pulse when a frame is discarded by the filter.

Function
REQ-015 ser_data SHALL pass a 2-flop synchroniser before use.
REQ-016 A tick SHALL occur every CLK_DIV clk cycles, counted by a free-running divider cleared by reset.
REQ-017 States: IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH; all transitions SHALL occur on ticks, except LATCH, which lasts exactly one clk.
REQ-018 IDLE: hold for GAP ticks with outputs idle high, then go to LOAD if enable=1; stay in IDLE if enable=0.
REQ-019 LOAD: ser_load=0 for exactly one tick, ser_clk=1, bit index cleared.
REQ-020 SHIFT_LO: ser_clk=0 for one tick; on entry, sample the synchronised ser_data, invert it, and store it at the bit index.
REQ-021 SHIFT_HI: ser_clk=1 for one tick, then increment the bit index; after bit PLAYERS*BITS-1, go to LATCH, otherwise go to SHIFT_LO.
REQ-022 Bit order: the first bit sampled is player 0 bit 0; bit n maps to joystick[n].
REQ-023 Frame length SHALL be 2 + 2*PLAYERS*BITS + GAP ticks, with exactly PLAYERS*BITS ser_clk low pulses per frame.
REQ-024 LATCH, identical frame:
- if the frame equals the previous raw frame, saturate-increment the match counter (3 bits);
- when the counter reaches FILTER-1 and the frame differs from joystick, load joystick and pulse valid in the same clk.
REQ-025 LATCH, differing frame: if the frame differs from the previous raw frame, clear the match counter, store the new raw frame, and pulse frame_err; joystick SHALL NOT change.
REQ-026 With FILTER=1, every frame that differs from joystick SHALL publish on its own LATCH.
REQ-027 Frames equal to the current joystick SHALL NOT pulse valid.
REQ-028 enable=0 during LOAD/SHIFT: at the next tick, abort to IDLE, discard the partial frame, and drive ser_clk and ser_load high; joystick, the raw frame and the match counter SHALL hold.
REQ-029 valid and frame_err SHALL never assert in the same cycle.

Reset
REQ-030 While reset is high:
- state=IDLE, GAP count restarted;
- ser_clk=1, ser_load=1;
- joystick=0, valid=0, frame_err=0;
- raw frame=0, match counter=0, synchroniser=1.
REQ-031 Reset asserted mid-frame SHALL take effect immediately; the first LOAD after release SHALL follow GAP ticks later.

Structure
REQ-032 A shared package SHALL hold:
- the state enum;
- constants MAX_PLAYERS=4 and MAX_BITS=16;
- a function that computes the frame width.
REQ-033 One sub-module, joy_tick_gen (divider producing the tick pulse), SHALL be instantiated; everything else is flat.

Verification
REQ-034 Reset release, enable=1, defaults: the first ser_load low pulse SHALL start 16 ticks (384 clks) after release; 24 ser_clk low pulses per frame; frame period 66 ticks = 1584 clks.
REQ-035 Chain model drives player0 = 12'hFFE (bit0 pressed) and player1 = 12'hFFF on every frame: after the 2nd LATCH, joystick=24'h000001 with exactly one valid pulse; no further valid pulses on later frames.
REQ-036 Single glitched frame with player1 bit3 low between clean frames: frame_err pulses twice (on the glitch and on the recovery); joystick and valid are unchanged.
REQ-037 Deassert enable at the 5th SHIFT_LO: within one tick, ser_clk=1 and ser_load=1; no LATCH occurs; on re-enable, a full 24-bit frame follows from LOAD.
REQ-038 Assert reset mid-SHIFT_HI with joystick=24'h000001: the same clk shows joystick=0 and lines high; no valid pulse until 2 clean frames after release.
REQ-039 PLAYERS=4, BITS=16, FILTER=1: a pattern of 64 unique bits SHALL be reproduced bit-exact in joystick after one frame, with valid pulsing once.
